note_scheduler: RTL and testbench
=================================

// Module: note_scheduler
// PURPOSE
//  Arbitrates NUM_KEYS raw piano-key inputs into one monophonic note for the square-wave tone divider.
//  Per key: synchronises and debounces the input.
//  Chooses the sounding key using last-note priority and looks up its divider period in PERIOD_TABLE.
//  Sequences the divider: one-cycle load strobe, gate on while playing, gate held through a fixed release tail.
//  Sits between the key pins and the tone divider (counter that wraps at tone_period).
// PARAMETERS
//  NUM_KEYS         8     number of key inputs (2..16)
//  DIV_W            17    width of divider period values
//  DEBOUNCE_CYCLES  4     consecutive stable cycles needed before a debounced key changes (>=1)
//  RELEASE_CYCLES   8     cycles gate stays high after the last key is released (>=1)
//  PERIOD_TABLE     {..}  NUM_KEYS*DIV_W packed; key k period = [k*DIV_W +: DIV_W]
//                         default k0..7 = 56817,50618,45097,42566,37920,33783,30097,28408
// PORTS
//  clk          in   1                       system clock, all logic on posedge
//  rst          in   1                       synchronous reset, active-high
//  keys         in   NUM_KEYS                raw asynchronous key levels, 1 = pressed
//  active_key   out  $clog2(NUM_KEYS)        index of the sounding key
//  tone_period  out  DIV_W                   wrap value for the tone divider
//  tone_load    out  1                       1-cycle strobe: divider must reload tone_period and restart from 0
//  gate         out  1                       1 = speaker enabled
// BEHAVIOUR
//  Reset
//   - On a rst-high clock edge, every output clears to 0: active_key, tone_period, tone_load, gate.
//   - Also cleared: sync flops, debounced state, debounce/release counters. FSM goes to IDLE.
//   - rst mid-note: outputs are 0 on the next edge. No tone_load is issued on reset exit.
//  Sync and debounce
//   - keys[k] passes through 2 flops.
//   - Per-key counter increments while the synced level differs from db[k]; it clears when they match.
//   - When the count reaches DEBOUNCE_CYCLES, db[k] flips and the counter clears.
//   - A glitch shorter than DEBOUNCE_CYCLES cycles never changes db[k].
//   - press[k] / rel[k] = 1-cycle rise / fall of db[k].
//  FSM states
//   - IDLE    gate=0. Any press -> LOAD.
//   - LOAD    tone_load=1, gate=1. tone_period and active_key are updated on entry. Next state -> PLAY.
//   - PLAY    gate=1.
//             Any press -> LOAD (new key).
//             rel of active key while other db keys are held -> LOAD with the lowest-index held key.
//             rel of active key with none held -> RELEASE; the release counter loads RELEASE_CYCLES-1.
//             rel of a non-active key -> no change.
//   - RELEASE gate=1; counter decrements.
//             Any press -> LOAD.
//             Counter==0 with no press -> IDLE; gate=0 on that edge.
//  Selection rules
//   - Several presses in the same cycle: the lowest index wins.
//   - A press in the same cycle as the active key's release: the press wins.
//   - Re-pressing the active key still issues LOAD, so the divider phase restarts.
//   - tone_period = PERIOD_TABLE[active_key]. Registered, and changes only on LOAD entry.
//  Latency
//   - Raw key edge to tone_load high: exactly 3+DEBOUNCE_CYCLES clock edges when no other event intervenes.
//   - Release: gate drops 3+DEBOUNCE_CYCLES+RELEASE_CYCLES edges after the raw release.
//  tone_load is never high for 2 consecutive cycles unless a new press arrives in LOAD.
//  That press is registered and taken on the following cycle.
// TESTING (defaults)
//  1 reset: assert rst with key0 held for 3 cycles -> all outputs 0 and no tone_load; after release the normal 7-cycle latency applies.
//  2 single note: keys=8'h01 held -> tone_load pulse exactly 7 edges later, tone_period=56817, active_key=0, gate=1;
//    release -> gate=0 15 edges after release.
//  3 glitch: keys[3]=1 for 3 cycles then 0 -> no tone_load, gate stays 0.
//  4 last-note priority: hold k2; after PLAY press k5 -> LOAD with 33783; release k5 -> LOAD back to k2 (45097), gate never drops.
//  5 simultaneous: keys 0->8'h90 in one cycle -> active_key=4, tone_period=37920.
//  6 release retrigger: release k0, press k7 during RELEASE count 3 -> LOAD with 28408, gate stays 1 throughout.
//  7 mid-note reset: rst during PLAY -> next edge gate=0, tone_period=0, FSM IDLE.

Source files
------------

// File: rtl/note_scheduler.sv
// Monophonic key arbiter: syncs/debounces NUM_KEYS keys, picks the sounding note by
// last-note priority and sequences the tone divider (load strobe, gate, release tail).

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic db,
    output logic press,
    output logic rel
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1, s2, db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            db_q <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= key;
            s2   <= s1;
            db_q <= db;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = db & ~db_q;
    assign rel   = ~db & db_q;
endmodule

module note_scheduler #(
    parameter int NUM_KEYS        = 8,
    parameter int DIV_W           = 17,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RELEASE_CYCLES  = 8,
    parameter logic [NUM_KEYS*DIV_W-1:0] PERIOD_TABLE = {
        17'd28408, 17'd30097, 17'd33783, 17'd37920,
        17'd42566, 17'd45097, 17'd50618, 17'd56817}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_KEYS-1:0]         keys,
    output logic [$clog2(NUM_KEYS)-1:0] active_key,
    output logic [DIV_W-1:0]            tone_period,
    output logic                        tone_load,
    output logic                        gate
);
    localparam int KW  = $clog2(NUM_KEYS);
    localparam int RCW = $clog2(RELEASE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, RELEASE} state_t;

    state_t               state, next_state;
    logic [NUM_KEYS-1:0]  db, press, rel;
    logic [RCW-1:0]       rel_cnt;
    logic [KW-1:0]        next_key;
    logic                 load;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst  (rst),
            .key  (keys[k]),
            .db   (db[k]),
            .press(press[k]),
            .rel  (rel[k])
        );
    end

    function automatic logic [KW-1:0] lowest(input logic [NUM_KEYS-1:0] v);
        lowest = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (v[i]) lowest = KW'(i);
    endfunction

    always_comb begin
        next_state = state;
        next_key   = active_key;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (|press) begin
                    next_state = LOAD;
                    next_key   = lowest(press);
                    load       = 1'b1;
                end
            end
            // LOAD shares PLAY's decisions so a release landing in the strobe cycle is not lost.
            LOAD, PLAY: begin
                next_state = PLAY;
                if (|press) begin
                    next_state = LOAD;
                    next_key   = lowest(press);
                    load       = 1'b1;
                end else if (rel[active_key]) begin
                    if (|db) begin
                        next_state = LOAD;
                        next_key   = lowest(db);
                        load       = 1'b1;
                    end else begin
                        next_state = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (|press) begin
                    next_state = LOAD;
                    next_key   = lowest(press);
                    load       = 1'b1;
                end else if (rel_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            active_key  <= '0;
            tone_period <= '0;
            rel_cnt     <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                active_key  <= next_key;
                tone_period <= PERIOD_TABLE[int'(next_key)*DIV_W +: DIV_W];
            end
            if (next_state == RELEASE && state != RELEASE)
                rel_cnt <= RCW'(RELEASE_CYCLES - 1);
            else if (state == RELEASE && rel_cnt != '0)
                rel_cnt <= rel_cnt - 1'b1;
        end
    end

    assign tone_load = (state == LOAD);
    assign gate      = (state != IDLE);
endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed vector table, a re-press sequence, and random key
// traffic checked every cycle against a behavioural model of the scheduling rules.

module tb_note_scheduler;
    localparam int DEB = 4;
    localparam int REL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  keys;
    logic [2:0]  active_key;
    logic [16:0] tone_period;
    logic        tone_load, gate;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    note_scheduler dut (
        .clk(clk), .rst(rst), .keys(keys), .active_key(active_key),
        .tone_period(tone_period), .tone_load(tone_load), .gate(gate)
    );

    // ---------------- behavioural model ----------------
    int          per_tab[8] = '{56817, 50618, 45097, 42566, 37920, 33783, 30097, 28408};
    logic [7:0]  m_s1, m_s2, m_db, m_dbq, pr, rl;
    int          m_run[8];
    int          m_tail;
    logic        m_gate, m_load;
    logic [2:0]  m_key;
    logic [16:0] m_per;

    function automatic logic [2:0] low_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_dbq = 0;
            foreach (m_run[i]) m_run[i] = 0;
            m_tail = -1; m_gate = 0; m_load = 0; m_key = 0; m_per = 0;
        end else begin
            pr = m_db & ~m_dbq;
            rl = ~m_db & m_dbq;
            m_load = 0;
            if (pr != 0) begin
                m_key = low_idx(pr); m_per = 17'(per_tab[m_key]);
                m_load = 1; m_gate = 1; m_tail = -1;
            end else if (m_gate && m_tail < 0 && rl[m_key]) begin
                if (m_db != 0) begin
                    m_key = low_idx(m_db); m_per = 17'(per_tab[m_key]); m_load = 1;
                end else begin
                    m_tail = REL - 1;
                end
            end else if (m_tail == 0) begin
                m_gate = 0; m_tail = -1;
            end else if (m_tail > 0) begin
                m_tail--;
            end
            m_dbq = m_db;
            for (int k = 0; k < 8; k++) begin
                if (m_s2[k] == m_db[k]) m_run[k] = 0;
                else begin
                    m_run[k]++;
                    if (m_run[k] >= DEB) begin m_db[k] = ~m_db[k]; m_run[k] = 0; end
                end
            end
            m_s2 = m_s1;
            m_s1 = keys;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({tone_load, gate, active_key, tone_period} !== {m_load, m_gate, m_key, m_per}) begin
                errors++;
                $display("FAIL model t=%0t got load=%0b gate=%0b key=%0d per=%0d exp load=%0b gate=%0b key=%0d per=%0d",
                         $time, tone_load, gate, active_key, tone_period, m_load, m_gate, m_key, m_per);
            end
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst;
        logic [7:0]  keys;
        int          n;
        logic        gate_all;
        logic        load;
        logic        gate;
        logic [2:0]  key;
        logic [16:0] per;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [7:0] k, input int n, input logic ga,
                       input logic ld, input logic g, input logic [2:0] ky, input logic [16:0] p);
        vec_t v;
        v.rst = r; v.keys = k; v.n = n; v.gate_all = ga;
        v.load = ld; v.gate = g; v.key = ky; v.per = p;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_load(input int max, output int lat, output bit gate_dropped);
        lat = -1;
        gate_dropped = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (!gate) gate_dropped = 1;
            if (tone_load) begin lat = i; break; end
        end
    endtask

    int  lat;
    bit  gd;

    initial begin
        rst = 1'b1; keys = 8'h00;
        // reset, reset with key held, single note and release tail
        add(1, 8'h00, 2, 0, 0, 0, 0, 0);
        add(1, 8'h01, 3, 0, 0, 0, 0, 0);
        add(0, 8'h01, 6, 0, 0, 0, 0, 0);
        add(0, 8'h01, 1, 0, 1, 1, 0, 56817);
        add(0, 8'h01, 1, 0, 0, 1, 0, 56817);
        add(0, 8'h00, 14, 1, 0, 1, 0, 56817);
        add(0, 8'h00, 1, 0, 0, 0, 0, 56817);
        // glitch shorter than the debounce window
        add(0, 8'h08, 3, 0, 0, 0, 0, 56817);
        add(0, 8'h00, 10, 0, 0, 0, 0, 56817);
        // last-note priority and fall-back to the lowest held key
        add(0, 8'h04, 7, 0, 1, 1, 2, 45097);
        add(0, 8'h04, 5, 0, 0, 1, 2, 45097);
        add(0, 8'h24, 7, 1, 1, 1, 5, 33783);
        add(0, 8'h24, 3, 0, 0, 1, 5, 33783);
        add(0, 8'h04, 7, 1, 1, 1, 2, 45097);
        add(0, 8'h04, 2, 0, 0, 1, 2, 45097);
        add(0, 8'h00, 16, 0, 0, 0, 2, 45097);
        // simultaneous presses
        add(0, 8'h90, 7, 0, 1, 1, 4, 37920);
        add(0, 8'h00, 16, 0, 0, 0, 4, 37920);
        // retrigger during the release tail (press seen at count 3)
        add(0, 8'h01, 7, 0, 1, 1, 0, 56817);
        add(0, 8'h01, 3, 0, 0, 1, 0, 56817);
        add(0, 8'h00, 5, 1, 0, 1, 0, 56817);
        add(0, 8'h80, 6, 1, 0, 1, 0, 56817);
        add(0, 8'h80, 1, 1, 1, 1, 7, 28408);
        add(0, 8'h80, 2, 0, 0, 1, 7, 28408);
        // mid-note reset, then a fresh press after reset exit
        add(1, 8'h80, 1, 0, 0, 0, 0, 0);
        add(0, 8'h80, 6, 0, 0, 0, 0, 0);
        add(0, 8'h80, 1, 0, 1, 1, 7, 28408);
        add(0, 8'h00, 16, 0, 0, 0, 7, 28408);
        // second press arriving during LOAD: back-to-back strobes
        add(0, 8'h02, 1, 0, 0, 0, 7, 28408);
        add(0, 8'h03, 6, 0, 1, 1, 1, 50618);
        add(0, 8'h03, 1, 0, 1, 1, 0, 56817);
        add(0, 8'h03, 1, 0, 0, 1, 0, 56817);
        add(0, 8'h00, 16, 0, 0, 0, 0, 56817);

        @(negedge clk);
        foreach (tbl[r]) begin
            rst = tbl[r].rst; keys = tbl[r].keys;
            for (int c = 0; c < tbl[r].n; c++) begin
                tick();
                if (r == 1) chk_en = 1'b1;
                if (tbl[r].gate_all) begin
                    checks++;
                    if (gate !== 1'b1) begin
                        errors++;
                        $display("FAIL row%0d_gate_held cycle %0d got gate=%0b exp 1", r, c, gate);
                    end
                end
            end
            checks++;
            if ({tone_load, gate, active_key, tone_period} !== {tbl[r].load, tbl[r].gate, tbl[r].key, tbl[r].per}) begin
                errors++;
                $display("FAIL row%0d got load=%0b gate=%0b key=%0d per=%0d exp load=%0b gate=%0b key=%0d per=%0d",
                         r, tone_load, gate, active_key, tone_period,
                         tbl[r].load, tbl[r].gate, tbl[r].key, tbl[r].per);
            end
        end

        // re-pressing the active key during its release tail must reload the divider
        keys = 8'h08;
        wait_load(20, lat, gd);
        checks++;
        if (lat != 7 || active_key !== 3'd3 || tone_period !== 17'd42566) begin
            errors++;
            $display("FAIL repress_first got lat=%0d key=%0d per=%0d exp lat=7 key=3 per=42566", lat, active_key, tone_period);
        end
        repeat (3) tick();
        keys = 8'h00;
        repeat (6) tick();
        keys = 8'h08;
        wait_load(20, lat, gd);
        checks++;
        if (lat != 7 || gd || active_key !== 3'd3 || tone_period !== 17'd42566) begin
            errors++;
            $display("FAIL repress_again got lat=%0d gate_dropped=%0b key=%0d exp lat=7 gate_dropped=0 key=3", lat, gd, active_key);
        end
        keys = 8'h00;
        repeat (20) tick();

        // random traffic: short and long holds, sparse keys, occasional reset
        for (int s = 0; s < 60; s++) begin
            int hold;
            hold = $urandom_range(1, 12);
            keys = 8'($urandom) & 8'($urandom) & 8'($urandom);
            rst  = ($urandom_range(0, 29) == 0);
            for (int c = 0; c < hold; c++) begin
                tick();
                rst = 1'b0;
            end
        end
        keys = 8'h00;
        repeat (25) tick();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
